// File: rtl/id_stage_if.sv
// Interface between the decode stage and its neighbours.
// It carries the fetch handshake, the registered ALU-side controls, the
// writeback port and the flush request.
// - slave  : the view used by id_stage
// - master : the view used by the surrounding pipeline or a testbench
interface id_stage_if;
    // fetch side
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    // ALU side
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        use_imm;
    logic [2:0]  op;
    logic        mod;
    logic        operand_2_neg;
    logic [4:0]  rd;
    logic        illegal;
    // writeback and pipeline control
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;

    modport slave (
        input  if_valid, if_instr, ex_ready, wb_en, wb_rd, wb_data, flush,
        output if_ready, ex_valid, rs1_val, rs2_val, imm, use_imm, op, mod,
               operand_2_neg, rd, illegal
    );

    modport master (
        output if_valid, if_instr, ex_ready, wb_en, wb_rd, wb_data, flush,
        input  if_ready, ex_valid, rs1_val, rs2_val, imm, use_imm, op, mod,
               operand_2_neg, rd, illegal
    );
endinterface

// File: rtl/id_stage.sv
// Decode / operand-fetch stage for RV32I ALU-class instructions (OP, OP-IMM,
// LUI). It holds the 32x32 register file, a busy-bit scoreboard for
// read-after-write interlock, and the output register that feeds the ALU.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - id_stage_if.slave: fetch handshake, ALU controls, writeback, flush
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.slave   bus
);

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_next_s;

    logic             ex_valid_r;
    logic [XLEN-1:0]  rs1_val_r;
    logic [XLEN-1:0]  rs2_val_r;
    logic [XLEN-1:0]  imm_r;
    logic             use_imm_r;
    logic [2:0]       op_r;
    logic             mod_r;
    logic             neg_r;
    logic [4:0]       rd_r;
    logic             illegal_r;

    logic [6:0]       opcode_s;
    logic [2:0]       funct3_s;
    logic [6:0]       funct7_s;
    logic [4:0]       rs1_idx_s;
    logic [4:0]       rs2_idx_s;
    logic [4:0]       rd_idx_s;

    logic             dec_illegal_s;
    logic             dec_use_imm_s;
    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_op_s;
    logic             dec_mod_s;
    logic             dec_neg_s;
    logic [4:0]       dec_rd_s;
    logic             use_rs1_s;
    logic             use_rs2_s;
    logic             opimm_legal_s;

    logic [XLEN-1:0]  rs1_rd_s;
    logic [XLEN-1:0]  rs2_rd_s;
    logic             hazard_s;
    logic             if_ready_s;
    logic             load_s;

    assign opcode_s  = bus.if_instr[6:0];
    assign rd_idx_s  = bus.if_instr[11:7];
    assign funct3_s  = bus.if_instr[14:12];
    assign rs1_idx_s = bus.if_instr[19:15];
    assign rs2_idx_s = bus.if_instr[24:20];
    assign funct7_s  = bus.if_instr[31:25];

    // Instruction decode; an illegal encoding leaves every control at zero.
    always_comb begin
        dec_illegal_s = 1'b1;
        dec_use_imm_s = 1'b0;
        dec_imm_s     = {XLEN{1'b0}};
        dec_op_s      = 3'b000;
        dec_mod_s     = 1'b0;
        dec_neg_s     = 1'b0;
        dec_rd_s      = 5'd0;
        use_rs1_s     = 1'b0;
        use_rs2_s     = 1'b0;
        opimm_legal_s = 1'b0;
        case (opcode_s)
            7'b0110011: begin
                if ((funct7_s == 7'b0000000) ||
                    ((funct7_s == 7'b0100000) &&
                     ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
                    dec_illegal_s = 1'b0;
                    dec_op_s      = funct3_s;
                    dec_neg_s     = (funct3_s == 3'b000) && bus.if_instr[30];
                    dec_mod_s     = (funct3_s == 3'b101) && bus.if_instr[30];
                    dec_rd_s      = rd_idx_s;
                    use_rs1_s     = 1'b1;
                    use_rs2_s     = 1'b1;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            7'b0010011: begin
                case (funct3_s)
                    3'b001:  opimm_legal_s = (funct7_s == 7'b0000000);
                    3'b101:  opimm_legal_s = (funct7_s == 7'b0000000) ||
                                             (funct7_s == 7'b0100000);
                    default: opimm_legal_s = 1'b1;
                endcase
                if (opimm_legal_s) begin
                    dec_illegal_s = 1'b0;
                    dec_use_imm_s = 1'b1;
                    dec_op_s      = funct3_s;
                    dec_rd_s      = rd_idx_s;
                    use_rs1_s     = 1'b1;
                    // shifts take a zero-extended shamt, everything else a sign-extended imm12
                    if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                        dec_imm_s = {27'b0, bus.if_instr[24:20]};
                        dec_mod_s = (funct3_s == 3'b101) && bus.if_instr[30];
                    end else begin
                        dec_imm_s = {{20{bus.if_instr[31]}}, bus.if_instr[31:20]};
                        dec_mod_s = 1'b0;
                    end
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            7'b0110111: begin
                dec_illegal_s = 1'b0;
                dec_use_imm_s = 1'b1;
                dec_imm_s     = {bus.if_instr[31:12], 12'b0};
                dec_rd_s      = rd_idx_s;
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Operand read with same-cycle writeback bypass; unused sources and x0 read 0.
    always_comb begin
        rs1_rd_s = {XLEN{1'b0}};
        rs2_rd_s = {XLEN{1'b0}};
        if (use_rs1_s && (rs1_idx_s != 5'd0)) begin
            if (bus.wb_en && (bus.wb_rd == rs1_idx_s)) begin
                rs1_rd_s = bus.wb_data;
            end else begin
                rs1_rd_s = regs_r[rs1_idx_s];
            end
        end else begin
            rs1_rd_s = {XLEN{1'b0}};
        end
        if (use_rs2_s && (rs2_idx_s != 5'd0)) begin
            if (bus.wb_en && (bus.wb_rd == rs2_idx_s)) begin
                rs2_rd_s = bus.wb_data;
            end else begin
                rs2_rd_s = regs_r[rs2_idx_s];
            end
        end else begin
            rs2_rd_s = {XLEN{1'b0}};
        end
    end

    // RAW interlock: a used, nonzero source that is busy and not being written back now.
    always_comb begin
        hazard_s = 1'b0;
        if (bus.if_valid) begin
            hazard_s = (use_rs1_s && (rs1_idx_s != 5'd0) && busy_r[rs1_idx_s] &&
                        !(bus.wb_en && (bus.wb_rd == rs1_idx_s))) ||
                       (use_rs2_s && (rs2_idx_s != 5'd0) && busy_r[rs2_idx_s] &&
                        !(bus.wb_en && (bus.wb_rd == rs2_idx_s)));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign if_ready_s = (!ex_valid_r || bus.ex_ready) && !hazard_s && !bus.flush;
    assign load_s     = bus.if_valid && if_ready_s;

    // Scoreboard next state: clears are applied first so a same-index set wins.
    always_comb begin
        busy_next_s = busy_r;
        if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            busy_next_s[bus.wb_rd] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (bus.flush && ex_valid_r && !illegal_r && (rd_r != 5'd0)) begin
            busy_next_s[rd_r] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (load_s && !dec_illegal_s && (dec_rd_s != 5'd0)) begin
            busy_next_s[dec_rd_s] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Register file, scoreboard and ALU-side output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
            busy_r     <= {NREGS{1'b0}};
            ex_valid_r <= 1'b0;
            rs1_val_r  <= {XLEN{1'b0}};
            rs2_val_r  <= {XLEN{1'b0}};
            imm_r      <= {XLEN{1'b0}};
            use_imm_r  <= 1'b0;
            op_r       <= 3'b000;
            mod_r      <= 1'b0;
            neg_r      <= 1'b0;
            rd_r       <= 5'd0;
            illegal_r  <= 1'b0;
        end else begin
            if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
                regs_r[bus.wb_rd] <= bus.wb_data;
            end
            busy_r <= busy_next_s;
            if (bus.flush) begin
                ex_valid_r <= 1'b0;
            end else if (load_s) begin
                ex_valid_r <= 1'b1;
                rs1_val_r  <= rs1_rd_s;
                rs2_val_r  <= rs2_rd_s;
                imm_r      <= dec_imm_s;
                use_imm_r  <= dec_use_imm_s;
                op_r       <= dec_op_s;
                mod_r      <= dec_mod_s;
                neg_r      <= dec_neg_s;
                rd_r       <= dec_rd_s;
                illegal_r  <= dec_illegal_s;
            end else if (bus.ex_ready) begin
                ex_valid_r <= 1'b0;
            end
        end
    end

    assign bus.if_ready      = if_ready_s;
    assign bus.ex_valid      = ex_valid_r;
    assign bus.rs1_val       = rs1_val_r;
    assign bus.rs2_val       = rs2_val_r;
    assign bus.imm           = imm_r;
    assign bus.use_imm       = use_imm_r;
    assign bus.op            = op_r;
    assign bus.mod           = mod_r;
    assign bus.operand_2_neg = neg_r;
    assign bus.rd            = rd_r;
    assign bus.illegal       = illegal_r;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage. Inputs change #1 after a rising edge and
// outputs are sampled at that same point (registered values) or after a
// further #1 (combinational if_ready).
module tb_id_stage;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [31:0] I_SUB_3_1_2   = 32'h402081B3;
    localparam logic [31:0] I_SRAI_4_1_5  = 32'h4050D213;
    localparam logic [31:0] I_ADDI_5_1_M1 = 32'hFFF08293;
    localparam logic [31:0] I_ADD_6_1_2   = 32'h00208333;
    localparam logic [31:0] I_ADD_7_6_6   = 32'h006303B3;
    localparam logic [31:0] I_JAL_X0      = 32'h0000006F;
    localparam logic [31:0] I_JAL_X1      = 32'h000000EF;
    localparam logic [31:0] I_ADD_10_1_1  = 32'h00108533;
    localparam logic [31:0] I_LUI_X0      = 32'h12345037;
    localparam logic [31:0] I_ADDI_8_0_1  = 32'h00100413;
    localparam logic [31:0] I_ADD_9_8_8   = 32'h008404B3;
    localparam logic [31:0] I_ADD_12_3_3  = 32'h00318633;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.if_valid = 1'b0; bus.if_instr = 32'h0; bus.ex_ready = 1'b1;
        bus.wb_en = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0; bus.flush = 1'b0;
        cyc(); cyc();
        tests_run++;
        if (bus.ex_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ex_valid got %0b want 0", bus.ex_valid); end
        tests_run++;
        if ({bus.rs1_val, bus.rs2_val, bus.imm} !== 96'h0) begin tests_failed++; $display("FAIL reset_data got %h %h %h want 0", bus.rs1_val, bus.rs2_val, bus.imm); end
        tests_run++;
        if ({bus.use_imm, bus.op, bus.mod, bus.operand_2_neg, bus.rd, bus.illegal} !== 12'h0) begin
            tests_failed++; $display("FAIL reset_ctrl got %b%b%b%b%b%b want 0", bus.use_imm, bus.op, bus.mod, bus.operand_2_neg, bus.rd, bus.illegal);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_if_ready got %0b want 1", bus.if_ready); end
        // preload x1=5, x2=3 through writeback
        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
        cyc();
        bus.wb_rd = 5'd2; bus.wb_data = 32'd3;
        cyc();
        bus.wb_en = 1'b0;
    endtask

    task automatic test_sub();
        bus.if_valid = 1'b1; bus.if_instr = I_SUB_3_1_2;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b1) begin tests_failed++; $display("FAIL sub_if_ready got %0b want 1", bus.if_ready); end
        cyc();
        bus.if_valid = 1'b0;
        tests_run++;
        if (bus.ex_valid !== 1'b1 || bus.rs1_val !== 32'd5 || bus.rs2_val !== 32'd3) begin
            tests_failed++; $display("FAIL sub_operands got v=%0b %h %h want 1 5 3", bus.ex_valid, bus.rs1_val, bus.rs2_val);
        end
        tests_run++;
        if (bus.op !== 3'd0 || bus.operand_2_neg !== 1'b1 || bus.use_imm !== 1'b0 || bus.rd !== 5'd3 || bus.illegal !== 1'b0) begin
            tests_failed++; $display("FAIL sub_ctrl got op=%0d neg=%0b ui=%0b rd=%0d ill=%0b want 0 1 0 3 0", bus.op, bus.operand_2_neg, bus.use_imm, bus.rd, bus.illegal);
        end
    endtask

    task automatic test_imm();
        bus.if_valid = 1'b1; bus.if_instr = I_SRAI_4_1_5;
        cyc();
        tests_run++;
        if (bus.use_imm !== 1'b1 || bus.imm !== 32'd5 || bus.op !== 3'd5 || bus.mod !== 1'b1 || bus.rd !== 5'd4 || bus.rs1_val !== 32'd5) begin
            tests_failed++; $display("FAIL srai got ui=%0b imm=%h op=%0d mod=%0b rd=%0d rs1=%h want 1 5 5 1 4 5", bus.use_imm, bus.imm, bus.op, bus.mod, bus.rd, bus.rs1_val);
        end
        bus.if_instr = I_ADDI_5_1_M1;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b1) begin tests_failed++; $display("FAIL addi_if_ready got %0b want 1", bus.if_ready); end
        cyc();
        bus.if_valid = 1'b0;
        tests_run++;
        if (bus.use_imm !== 1'b1 || bus.imm !== 32'hFFFFFFFF || bus.op !== 3'd0 || bus.mod !== 1'b0 || bus.rd !== 5'd5) begin
            tests_failed++; $display("FAIL addi got ui=%0b imm=%h op=%0d mod=%0b rd=%0d want 1 ffffffff 0 0 5", bus.use_imm, bus.imm, bus.op, bus.mod, bus.rd);
        end
    endtask

    task automatic test_hazard_bypass();
        bus.if_valid = 1'b1; bus.if_instr = I_ADD_6_1_2;
        cyc();
        tests_run++;
        if (bus.rd !== 5'd6 || bus.rs1_val !== 32'd5 || bus.rs2_val !== 32'd3) begin
            tests_failed++; $display("FAIL add6 got rd=%0d %h %h want 6 5 3", bus.rd, bus.rs1_val, bus.rs2_val);
        end
        bus.if_instr = I_ADD_7_6_6;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b0) begin tests_failed++; $display("FAIL hazard_stall1 got %0b want 0", bus.if_ready); end
        cyc();
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b0 || bus.ex_valid !== 1'b0) begin
            tests_failed++; $display("FAIL hazard_stall2 got rdy=%0b v=%0b want 0 0", bus.if_ready, bus.ex_valid);
        end
        bus.wb_en = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'd8;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b1) begin tests_failed++; $display("FAIL hazard_release got %0b want 1", bus.if_ready); end
        cyc();
        bus.wb_en = 1'b0; bus.if_valid = 1'b0;
        tests_run++;
        if (bus.ex_valid !== 1'b1 || bus.rd !== 5'd7 || bus.rs1_val !== 32'd8 || bus.rs2_val !== 32'd8) begin
            tests_failed++; $display("FAIL bypass got v=%0b rd=%0d %h %h want 1 7 8 8", bus.ex_valid, bus.rd, bus.rs1_val, bus.rs2_val);
        end
    endtask

    task automatic test_stall();
        bus.ex_ready = 1'b0; bus.if_valid = 1'b1; bus.if_instr = I_ADDI_5_1_M1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.if_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_if_ready[%0d] got %0b want 0", i, bus.if_ready); end
            cyc();
            tests_run++;
            if (bus.ex_valid !== 1'b1 || bus.rd !== 5'd7 || bus.rs1_val !== 32'd8 || bus.rs2_val !== 32'd8 || bus.use_imm !== 1'b0) begin
                tests_failed++; $display("FAIL stall_hold[%0d] got v=%0b rd=%0d %h %h ui=%0b want 1 7 8 8 0", i, bus.ex_valid, bus.rd, bus.rs1_val, bus.rs2_val, bus.use_imm);
            end
        end
        bus.ex_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release got %0b want 1", bus.if_ready); end
        cyc();
        tests_run++;
        if (bus.rd !== 5'd5 || bus.imm !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL b2b_first got rd=%0d imm=%h want 5 ffffffff", bus.rd, bus.imm); end
        bus.if_instr = I_SRAI_4_1_5;
        cyc();
        bus.if_valid = 1'b0;
        tests_run++;
        if (bus.ex_valid !== 1'b1 || bus.rd !== 5'd4 || bus.imm !== 32'd5) begin
            tests_failed++; $display("FAIL b2b_second got v=%0b rd=%0d imm=%h want 1 4 5", bus.ex_valid, bus.rd, bus.imm);
        end
        cyc();
        tests_run++;
        if (bus.ex_valid !== 1'b0) begin tests_failed++; $display("FAIL drain got %0b want 0", bus.ex_valid); end
    endtask

    task automatic test_illegal_lui();
        bus.if_valid = 1'b1; bus.if_instr = I_JAL_X0;
        cyc();
        tests_run++;
        if (bus.ex_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.rd !== 5'd0 || bus.use_imm !== 1'b0 || bus.imm !== 32'h0 || bus.rs1_val !== 32'h0) begin
            tests_failed++; $display("FAIL jal got v=%0b ill=%0b rd=%0d ui=%0b imm=%h rs1=%h want 1 1 0 0 0 0", bus.ex_valid, bus.illegal, bus.rd, bus.use_imm, bus.imm, bus.rs1_val);
        end
        bus.if_instr = I_JAL_X1;
        cyc();
        tests_run++;
        if (bus.illegal !== 1'b1 || bus.rd !== 5'd0) begin tests_failed++; $display("FAIL jal_x1 got ill=%0b rd=%0d want 1 0", bus.illegal, bus.rd); end
        // x1 must not have been marked busy by the illegal jal x1
        bus.if_instr = I_ADD_10_1_1;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b1) begin tests_failed++; $display("FAIL illegal_no_busy got %0b want 1", bus.if_ready); end
        cyc();
        tests_run++;
        if (bus.rd !== 5'd10 || bus.rs1_val !== 32'd5 || bus.illegal !== 1'b0) begin
            tests_failed++; $display("FAIL add10 got rd=%0d rs1=%h ill=%0b want 10 5 0", bus.rd, bus.rs1_val, bus.illegal);
        end
        bus.if_instr = I_LUI_X0;
        cyc();
        bus.if_valid = 1'b0;
        tests_run++;
        if (bus.imm !== 32'h12345000 || bus.rs1_val !== 32'h0 || bus.rd !== 5'd0 || bus.use_imm !== 1'b1 || bus.op !== 3'd0 || bus.illegal !== 1'b0) begin
            tests_failed++; $display("FAIL lui got imm=%h rs1=%h rd=%0d ui=%0b op=%0d ill=%0b want 12345000 0 0 1 0 0", bus.imm, bus.rs1_val, bus.rd, bus.use_imm, bus.op, bus.illegal);
        end
    endtask

    task automatic test_flush();
        bus.if_valid = 1'b1; bus.if_instr = I_ADDI_8_0_1;
        cyc();
        bus.if_valid = 1'b0; bus.ex_ready = 1'b0;
        tests_run++;
        if (bus.ex_valid !== 1'b1 || bus.rd !== 5'd8 || bus.imm !== 32'd1) begin
            tests_failed++; $display("FAIL addi8 got v=%0b rd=%0d imm=%h want 1 8 1", bus.ex_valid, bus.rd, bus.imm);
        end
        cyc();
        bus.flush = 1'b1;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b0 || bus.ex_valid !== 1'b1) begin
            tests_failed++; $display("FAIL flush_held got rdy=%0b v=%0b want 0 1", bus.if_ready, bus.ex_valid);
        end
        cyc();
        bus.flush = 1'b0;
        tests_run++;
        if (bus.ex_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_kill got %0b want 0", bus.ex_valid); end
        bus.ex_ready = 1'b1; bus.if_valid = 1'b1; bus.if_instr = I_ADD_9_8_8;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_busy_clear got %0b want 1", bus.if_ready); end
        cyc();
        bus.if_valid = 1'b0;
        tests_run++;
        if (bus.ex_valid !== 1'b1 || bus.rd !== 5'd9 || bus.rs1_val !== 32'h0) begin
            tests_failed++; $display("FAIL add9 got v=%0b rd=%0d rs1=%h want 1 9 0", bus.ex_valid, bus.rd, bus.rs1_val);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.ex_ready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; bus.ex_ready = 1'b1;
        tests_run++;
        if (bus.ex_valid !== 1'b0 || bus.rd !== 5'd0) begin
            tests_failed++; $display("FAIL rst_stall got v=%0b rd=%0d want 0 0", bus.ex_valid, bus.rd);
        end
        // x3 was busy before reset; it must now issue without a stall
        bus.if_valid = 1'b1; bus.if_instr = I_ADD_12_3_3;
        #1;
        tests_run++;
        if (bus.if_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_busy_clear got %0b want 1", bus.if_ready); end
        cyc();
        bus.if_instr = I_ADD_10_1_1;
        cyc();
        bus.if_valid = 1'b0;
        tests_run++;
        if (bus.rd !== 5'd10 || bus.rs1_val !== 32'h0 || bus.rs2_val !== 32'h0) begin
            tests_failed++; $display("FAIL rst_regfile got rd=%0d %h %h want 10 0 0", bus.rd, bus.rs1_val, bus.rs2_val);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_sub();
        test_imm();
        test_hazard_bypass();
        test_stall();
        test_illegal_lui();
        test_flush();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU wrapper.
- Accepts RV32I ALU-class instructions (OP, OP-IMM, LUI) from fetch over a valid/ready handshake.
- Reads an internal 32x32 register file and drives registered ALU controls: rs1_val, rs2_val, imm, use_imm, op, mod, operand_2_neg.
- A busy-bit scoreboard interlocks read-after-write hazards until writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch offers an instruction.
- if_instr  in  32  instruction word.
- if_ready  out  1  stage accepts the instruction this cycle.
- ex_valid  out  1  output register holds a decoded instruction.
- ex_ready  in  1  ALU side consumes the output this cycle.
- rs1_val  out  32  operand 1.
- rs2_val  out  32  register operand 2.
- imm  out  32  immediate operand.
- use_imm  out  1  ALU selects imm over rs2_val.
- op  out  3  ALU operation (funct3 encoding).
- mod  out  1  arithmetic-shift modifier.
- operand_2_neg  out  1  negate operand 2 (SUB).
- rd  out  5  destination register.
- illegal  out  1  decoded instruction is not supported.
- wb_en  in  1  writeback enable.
- wb_rd  in  5  writeback register index.
- wb_data  in  32  writeback value.
- flush  in  1  kill the instruction in the output register.

Behaviour:
- Reset (synchronous, active-high): all 32 registers cleared to 0; busy vector cleared to 0; ex_valid=0; every output register (rs1_val, rs2_val, imm, use_imm, op, mod, operand_2_neg, rd, illegal) cleared to 0.
- Output register update condition: load = if_valid && if_ready.
- if_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- Latency: one cycle. Outputs are valid the cycle after acceptance.
- Outputs hold stable while ex_valid && !ex_ready.
- On ex_ready && !load, ex_valid drops to 0.
- Hazard: asserted when any source register actually used by the instruction has its busy bit set and is not being written by wb this cycle.
  - Sources used: rs1 for OP and OP-IMM; rs2 for OP only.
  - Hazard is never raised for x0 or when the instruction is illegal.
- Register-file read bypass: if wb_en and wb_rd equals the source index (nonzero), the read returns wb_data in the same cycle. x0 always reads 0.
- Writes to x0 are ignored.
- Decode, by opcode = instr[6:0]:
  - 0110011 OP: use_imm=0; op=funct3. funct7 must be 0000000, or 0100000 with funct3 equal to 000 or 101. operand_2_neg=1 for funct3=000 with instr[30]=1 (SUB). mod=1 for funct3=101 with instr[30]=1 (SRA).
  - 0010011 OP-IMM: use_imm=1; op=funct3. Non-shift ops: imm = sign-extended instr[31:20]. Shift ops (funct3 001 or 101): imm = {27'b0, instr[24:20]}; mod = instr[30] only when funct3=101. Shift legality: funct7 must be 0000000 for 001; 0000000 or 0100000 for 101.
  - 0110111 LUI: rs1_val=0; use_imm=1; imm = {instr[31:12], 12'b0}; op=000; mod=0; operand_2_neg=0.
  - Anything else, or a failed legality check: illegal=1. rd, op, mod, operand_2_neg, use_imm, imm, rs1_val and rs2_val are all 0. The instruction is still accepted and presented with ex_valid=1.
- Scoreboard:
  - On load of a legal instruction with rd!=0, busy[rd] is set.
  - On wb_en with wb_rd!=0, busy[wb_rd] is cleared.
  - If a set and a clear hit the same index in the same cycle, the set wins.
- Flush:
  - ex_valid is cleared next cycle.
  - If the held instruction was legal with rd!=0, its busy bit is cleared; this clear loses to nothing (no load occurs, since if_ready=0).
  - Writeback still proceeds during flush.
- Reset asserted mid-stall overrides everything; the held instruction is discarded.

Test Plan:
- Reset, then write x1=5 and x2=3 via wb. Issue 0x402081B3 (sub x3,x1,x2) -> next cycle ex_valid=1, rs1_val=5, rs2_val=3, op=0, operand_2_neg=1, use_imm=0, rd=3.
- Issue 0x4050D213 (srai x4,x1,5) -> use_imm=1, imm=5, op=5, mod=1; 0xFFF08293 (addi x5,x1,-1) -> imm=0xFFFFFFFF, mod=0.
- Issue add x6,x1,x2, then add x7,x6,x6 -> if_ready=0 until wb_en with wb_rd=6 and wb_data=8. In that wb cycle the second instruction is accepted with rs1_val=rs2_val=8 (bypass).
- Hold ex_ready=0 for 3 cycles with ex_valid=1 -> all outputs stable, if_ready=0. Then ex_ready=1 with if_valid=1 -> back-to-back acceptance.
- Issue 0x0000006F (JAL) -> ex_valid=1, illegal=1, rd=0, no busy bit set. Issue 0x12345037 (lui x0) -> imm=0x12345000, rs1_val=0, rd=0, no busy bit set.
- Issue addi x8,x0,1, then assert flush while it is held -> ex_valid=0 next cycle, busy[8]=0. A subsequent add x9,x8,x8 is accepted with no stall.
